// File: rtl/mm_mac_engine.sv
// rtl/mm_mac_engine.sv - sequential N x N unsigned matrix multiply, C = A x B
// One multiplier and one accumulator reused per element; A/B memories have 1-cycle read latency.
module mm_mac_engine #(
   parameter int N    = 4,
   parameter int DW   = 8,
   parameter int AW   = 4,
   parameter int ACCW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [AW-1:0]   a_addr,
   input  logic [DW-1:0]   a_rdata,
   output logic [AW-1:0]   b_addr,
   input  logic [DW-1:0]   b_rdata,
   output logic            c_we,
   output logic [AW-1:0]   c_addr,
   output logic [ACCW-1:0] c_wdata,
   output logic            busy,
   output logic            done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ACC   = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [AW-1:0] NL   = AW'(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   logic [2:0]      state;
   logic [AW-1:0]   i;
   logic [AW-1:0]   j;
   logic [AW-1:0]   k;
   logic [ACCW-1:0] acc;

   logic [2*DW-1:0] prod;
   logic [ACCW-1:0] acc_sum;
   logic [AW-1:0]   k_nx;
   logic [AW-1:0]   i_nx;
   logic [AW-1:0]   j_nx;

   assign prod    = a_rdata * b_rdata;
   assign acc_sum = acc + ACCW'(prod);
   assign k_nx    = k + ONE;
   assign j_nx    = (j == LAST) ? '0 : j + ONE;
   assign i_nx    = (j == LAST) ? i + ONE : i;

   assign busy = (state == S_FETCH) || (state == S_ACC) || (state == S_WRITE);

   // Addresses are loaded on the edge that enters FETCH so the memory
   // samples them during FETCH and returns data during ACC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         i       <= '0;
         j       <= '0;
         k       <= '0;
         acc     <= '0;
         a_addr  <= '0;
         b_addr  <= '0;
         c_addr  <= '0;
         c_wdata <= '0;
         c_we    <= 1'b0;
         done    <= 1'b0;
      end else begin
         c_we <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  i      <= '0;
                  j      <= '0;
                  k      <= '0;
                  acc    <= '0;
                  a_addr <= '0;
                  b_addr <= '0;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_ACC;
            end
            S_ACC: begin
               acc <= acc_sum;
               if (k != LAST) begin
                  k      <= k_nx;
                  a_addr <= i * NL + k_nx;
                  b_addr <= k_nx * NL + j;
                  state  <= S_FETCH;
               end else begin
                  c_we    <= 1'b1;
                  c_addr  <= i * NL + j;
                  c_wdata <= acc_sum;
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               k   <= '0;
               acc <= '0;
               if ((i == LAST) && (j == LAST)) begin
                  i     <= '0;
                  j     <= '0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  i      <= i_nx;
                  j      <= j_nx;
                  a_addr <= i_nx * NL;
                  b_addr <= j_nx;
                  state  <= S_FETCH;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mm_mac_engine.md
Name: mm_mac_engine

Overview:
- Sequential matrix-multiply datapath: computes C = A x B for two N x N unsigned matrices.
- Reads A and B from two synchronous-read memories (1-cycle read latency) and writes C to a result memory.
- Sits directly upstream of the result/LED display logic in mmmain_top; that logic reads C after done.
- One multiplier and one accumulator, reused for every element.

Parameters:
N, 4, matrix dimension (N >= 2)
DW, 8, element width of A and B (unsigned)
AW, 4, address width of all three memories; N*N <= 2^AW
ACCW, 32, accumulator and C element width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin one multiply; sampled only in IDLE
a_addr  out  AW  A read address, row-major (i*N+k)
a_rdata  in  DW  A read data, valid the cycle after a_addr
b_addr  out  AW  B read address, row-major (k*N+j)
b_rdata  in  DW  B read data, valid the cycle after b_addr
c_we  out  1  C write enable, one-cycle pulse per element
c_addr  out  AW  C write address, row-major (i*N+j)
c_wdata  out  ACCW  C write data
busy  out  1  high from the first FETCH through the final WRITE
done  out  1  one-cycle pulse after the final C write

Behaviour:
Reset:
- rst high at an edge: state=IDLE; i=j=k=0; acc=0.
- All outputs 0 (a_addr, b_addr, c_addr, c_wdata, c_we, busy, done).
- Reset mid-operation aborts immediately. No further c_we occurs, and C contents already written are left as they are.

FSM states and transitions:
- IDLE: busy=0. start=1 -> FETCH with i=j=k=0, acc=0. start=0 -> stay.
- FETCH: a_addr=i*N+k, b_addr=k*N+j. Always -> ACC next cycle.
- ACC: acc <= acc + a_rdata*b_rdata.
  - k<N-1: k++ and -> FETCH.
  - k==N-1: -> WRITE.
- WRITE: c_we=1, c_addr=i*N+j, c_wdata=final acc (includes the last product). Then k=0, acc=0, and advance j (and i when j wraps at N-1).
  - Element (N-1,N-1) just written -> DONE.
  - Otherwise -> FETCH.
- DONE: done=1 for exactly one cycle, busy=0. -> IDLE.

Output registering:
- a_addr, b_addr, c_addr, c_wdata, c_we and done are registered, so they change only on clock edges.
- Addresses hold their last value outside FETCH. c_we=0 outside WRITE.

Arithmetic:
- Product is DW x DW unsigned, giving 2*DW bits, zero-extended to ACCW.
- Accumulation is modulo 2^ACCW; no saturation and no overflow flag.

Latency:
- Each element takes 2N+1 cycles (N x FETCH/ACC pairs + 1 WRITE).
- Total is N*N*(2N+1) cycles from the first FETCH to the last WRITE. For N=4 that is 144.
- done is high in the cycle immediately after the last WRITE.
- C is written in order C[0][0], C[0][1], ..., C[N-1][N-1].

Boundary conditions:
- start while busy or in DONE: ignored.
- start held high continuously: a new run begins from the IDLE that follows DONE.
- start and rst high together: rst wins.
- Read data is consumed only in ACC. Any a_rdata/b_rdata value in other cycles is don't-care.

Test Plan:
1. A = 0..15 row-major, B = identity, pulse start -> 16 c_we pulses with C[n] = n in address order 0..15; done exactly 145 cycles after the start-sampling edge; busy high for 144 cycles.
2. A[i][k] = i+k, B all 2 -> C[i][j] = 8i+12 (row0 = 12, row3 = 36) for every j.
3. A and B all 255 (DW=8) -> every C = 260100. Rerun with ACCW=16 -> every C = 63492 (wrap).
4. Pulse start again at cycle 20 of an active run -> no restart, still exactly 16 writes, single done pulse.
5. Assert rst at cycle 50 of a run -> next cycle c_we=0, busy=0, addresses 0. A fresh start then produces the full correct C and done after 145 cycles.
6. Hold start high across two runs -> two complete runs back to back, each with 16 writes and one done pulse; IDLE lasts one cycle between them.
